// File: rtl/lz77_decoder_pkg.sv
// Shared LZ77 constants and decoder state encoding (also used by the encoder side).
package lz77_pkg;
  localparam int SB_LEN = 30;
  localparam int LA_LEN = 25;
  localparam int CHAR_W = 4;
  localparam int TOTAL  = 8192;
  localparam int OFF_W  = 5;
  localparam int LEN_W  = 5;
  localparam int CNT_W  = 14;
  localparam logic [7:0] EOF_CHAR = 8'h24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/lz77_decoder_if.sv
// Token input / symbol output bundle between the token source and the decoder.
interface lz77_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] offset;
  logic [4:0] match_len;
  logic [7:0] char_nxt;
  logic       out_valid;
  logic [7:0] char_out;
  logic       finish;
  logic       err;

  modport master (
    output in_valid, offset, match_len, char_nxt,
    input  in_ready, out_valid, char_out, finish, err
  );

  modport slave (
    input  in_valid, offset, match_len, char_nxt,
    output in_ready, out_valid, char_out, finish, err
  );
endinterface

// File: rtl/lz77_decoder_search_window.sv
// Search window: shift register of the most recent symbols, win_q[0] newest.
module lz77_search_window
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en_i,
  input  logic [CHAR_W-1:0] din_i,
  input  logic [OFF_W-1:0]  rd_idx_i,
  output logic [CHAR_W-1:0] rd_data_o
);
  logic [CHAR_W-1:0] win_q [SB_LEN];

  // Shift a new symbol in at index 0, ageing every older entry by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SB_LEN; k++) win_q[k] <= '0;
    end else if (shift_en_i) begin
      win_q[0] <= din_i;
      for (int k = 1; k < SB_LEN; k++) win_q[k] <= win_q[k-1];
    end
  end

  // Indices beyond the window read as zero so the read never leaves the array.
  assign rd_data_o = (rd_idx_i < OFF_W'(SB_LEN)) ? win_q[rd_idx_i] : '0;
endmodule

// File: rtl/lz77_decoder.sv
// LZ77 token decoder: expands (offset, match_len, char_nxt) into one symbol per cycle.
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  lz77_decoder_if.slave bus
);
  state_t            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        nxt_q, nxt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        char_out_q, char_out_d;
  logic              finish_q, finish_d;
  logic              err_q, err_d;

  logic              in_ready;
  logic              accept;
  logic              take;
  logic              bump;
  logic              win_shift;
  logic [CHAR_W-1:0] win_din;
  logic [CHAR_W-1:0] win_rd;

  lz77_search_window u_window (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (win_shift),
    .din_i      (win_din),
    .rd_idx_i   (off_q),
    .rd_data_o  (win_rd)
  );

  assign in_ready = (state_q == IDLE) || (state_q == LAST);
  assign accept   = bus.in_valid && in_ready;

  // Next-state logic: emit copies/literal, count symbols, latch chained tokens, flag errors.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    len_d       = len_q;
    nxt_d       = nxt_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    char_out_d  = char_out_q;
    finish_d    = finish_q;
    err_d       = err_q;
    take        = 1'b0;
    bump        = 1'b0;
    win_shift   = 1'b0;
    win_din     = nxt_q[CHAR_W-1:0];

    case (state_q)
      IDLE: begin
        take = accept;
      end
      COPY: begin
        char_out_d  = {4'b0, win_rd};
        out_valid_d = 1'b1;
        win_shift   = 1'b1;
        win_din     = win_rd;
        bump        = 1'b1;
        len_d       = len_q - 1'b1;
        if (len_q == LEN_W'(1)) state_d = LAST;
      end
      LAST: begin
        if (nxt_q == EOF_CHAR) begin
          // End token: no symbol, any token offered now is dropped.
          finish_d = 1'b1;
          state_d  = DONE;
          if (cnt_q != CNT_W'(TOTAL)) err_d = 1'b1;
        end else begin
          char_out_d  = {4'b0, nxt_q[CHAR_W-1:0]};
          out_valid_d = 1'b1;
          win_shift   = 1'b1;
          bump        = 1'b1;
          state_d     = IDLE;
          take        = accept;
        end
      end
      default: ;
    endcase

    if (bump) begin
      if (cnt_q == CNT_W'(TOTAL)) err_d = 1'b1;
      else                        cnt_d = cnt_q + 1'b1;
    end

    // Offsets are checked against the history including this cycle's symbol.
    if (take) begin
      off_d   = bus.offset;
      len_d   = bus.match_len;
      nxt_d   = bus.char_nxt;
      state_d = (bus.match_len == '0) ? LAST : COPY;
      if (bus.match_len > LEN_W'(LA_LEN - 1)) err_d = 1'b1;
      if (bus.match_len != '0) begin
        if (bus.offset > OFF_W'(SB_LEN - 1))                 err_d = 1'b1;
        if ({{(CNT_W-OFF_W){1'b0}}, bus.offset} >= cnt_d)     err_d = 1'b1;
      end
    end
  end

  // State, token and output registers; reset aborts any token in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      off_q       <= '0;
      len_q       <= '0;
      nxt_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      char_out_q  <= '0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      len_q       <= len_d;
      nxt_q       <= nxt_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      char_out_q  <= char_out_d;
      finish_q    <= finish_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.char_out  = char_out_q;
  assign bus.finish    = finish_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_lz77_decoder.sv
// Directed bench for lz77_decoder: hand-computed symbol streams, timing and error flags.
module tb_lz77_decoder;
  import lz77_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   dollar_cnt = 0;
  logic [7:0] oq_val[$];
  int         oq_cyc[$];

  lz77_decoder_if bus ();

  lz77_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: record every emitted symbol and the cycle it appeared in.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      oq_val.push_back(bus.char_out);
      oq_cyc.push_back(cyc);
      if (bus.char_out == 8'h24) dollar_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] o, input logic [4:0] l, input logic [7:0] c, output int acc);
    int w;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.offset    = o;
    bus.match_len = l;
    bus.char_nxt  = c;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck low, token %0d/%0d/%0h", o, l, c);
      bus.in_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    oq_val.delete();
    oq_cyc.delete();
    dollar_cnt = 0;
  endtask

  task automatic check_out(input string tag, input int first_cyc, input logic [7:0] e[$]);
    check({tag, "_count"}, oq_val.size(), e.size());
    if (oq_val.size() == e.size() && e.size() > 0) begin
      check({tag, "_first_cycle"}, oq_cyc[0], first_cyc);
      for (int i = 0; i < e.size(); i++) begin
        check($sformatf("%s_sym%0d", tag, i), oq_val[i], e[i]);
        check($sformatf("%s_cyc%0d", tag, i), oq_cyc[i], oq_cyc[0] + i);
      end
    end
  endtask

  initial begin
    int a, b, e_acc, bad;
    logic [7:0] exp_q[$];

    bus.in_valid  = 1'b0;
    bus.offset    = '0;
    bus.match_len = '0;
    bus.char_nxt  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_char_out",  bus.char_out, 8'h00);
    check("rst_finish",    bus.finish, 1'b0);
    check("rst_err",       bus.err, 1'b0);
    check("rst_in_ready",  bus.in_ready, 1'b1);
    reset = 1'b0;

    // 1: reset in the middle of a copy
    do_reset();
    send(5'd0, 5'd0, 8'h01, a);
    send(5'd0, 5'd10, 8'h02, a);
    idle();
    repeat (2) @(negedge clk);
    check("t1_busy", bus.out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("t1_out_valid", bus.out_valid, 1'b0);
    check("t1_finish",    bus.finish, 1'b0);
    check("t1_err",       bus.err, 1'b0);
    check("t1_in_ready",  bus.in_ready, 1'b1);
    reset = 1'b0;
    oq_val.delete();
    oq_cyc.delete();
    send(5'd0, 5'd0, 8'h07, a);
    idle();
    repeat (4) @(negedge clk);
    exp_q = '{8'h07};
    check_out("t1_restart", a + 1, exp_q);

    // 2: single literal, latency and ready recovery
    do_reset();
    send(5'd0, 5'd0, 8'h03, a);
    idle();
    repeat (5) @(negedge clk);
    exp_q = '{8'h03};
    check_out("t2", a + 1, exp_q);
    check("t2_in_ready", bus.in_ready, 1'b1);
    check("t2_err", bus.err, 1'b0);

    // 3: overlapping copy
    do_reset();
    send(5'd0, 5'd0, 8'h01, a);
    send(5'd0, 5'd4, 8'h02, b);
    idle();
    repeat (10) @(negedge clk);
    exp_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
    check_out("t3", a + 1, exp_q);
    check("t3_err", bus.err, 1'b0);

    // 4: window indexing with chained tokens
    do_reset();
    send(5'd0, 5'd0, 8'h01, a);
    send(5'd0, 5'd0, 8'h02, b);
    send(5'd0, 5'd0, 8'h03, b);
    send(5'd2, 5'd3, 8'h04, b);
    idle();
    repeat (10) @(negedge clk);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    check_out("t4", a + 1, exp_q);
    check("t4_err", bus.err, 1'b0);

    // 5a: full-length stream then end token
    do_reset();
    send(5'd0, 5'd0, 8'h01, a);
    for (int i = 0; i < 327; i++) send(5'd0, 5'd24, 8'h01, a);
    send(5'd0, 5'd15, 8'h01, a);
    send(5'd0, 5'd0, EOF_CHAR, e_acc);
    check("t5_finish_at_accept", bus.finish, 1'b0);
    idle();
    @(posedge clk);
    #1;
    check("t5_finish_next_edge", bus.finish, 1'b1);
    check("t5_no_eof_emit", bus.out_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_count", oq_val.size(), 8192);
    check("t5_dollar", dollar_cnt, 0);
    check("t5_err", bus.err, 1'b0);
    check("t5_done_ready", bus.in_ready, 1'b0);
    bad = 0;
    foreach (oq_val[i]) if (oq_val[i] !== 8'h01) bad++;
    check("t5_values", bad, 0);

    // 5b: short stream then end token
    do_reset();
    send(5'd0, 5'd0, 8'h01, a);
    for (int i = 0; i < 3; i++) send(5'd0, 5'd24, 8'h01, a);
    send(5'd0, 5'd23, 8'h01, a);
    send(5'd0, 5'd0, EOF_CHAR, e_acc);
    idle();
    repeat (4) @(negedge clk);
    check("t5b_count", oq_val.size(), 100);
    check("t5b_finish", bus.finish, 1'b1);
    check("t5b_err", bus.err, 1'b1);

    // 6a: offset reaching past written history
    do_reset();
    send(5'd0, 5'd0, 8'h01, a);
    send(5'd0, 5'd0, 8'h02, a);
    send(5'd0, 5'd0, 8'h03, a);
    check("t6a_err_before", bus.err, 1'b0);
    send(5'd29, 5'd2, 8'h05, a);
    idle();
    repeat (6) @(negedge clk);
    check("t6a_err", bus.err, 1'b1);

    // 6b: match length beyond lookahead span
    do_reset();
    send(5'd0, 5'd0, 8'h01, a);
    send(5'd0, 5'd0, 8'h02, a);
    send(5'd0, 5'd0, 8'h03, a);
    send(5'd0, 5'd25, 8'h05, a);
    idle();
    repeat (30) @(negedge clk);
    check("t6b_err", bus.err, 1'b1);

    // 6c: offset ignored for a pure literal
    do_reset();
    send(5'd0, 5'd0, 8'h01, a);
    send(5'd0, 5'd0, 8'h02, b);
    send(5'd0, 5'd0, 8'h03, b);
    send(5'd7, 5'd0, 8'h05, b);
    idle();
    repeat (5) @(negedge clk);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h05};
    check_out("t6c", a + 1, exp_q);
    check("t6c_err", bus.err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
